uart_rx_fifo: RTL

//  Receive-side byte buffer directly downstream of the UART receiver.
//  - Detects each new received byte from the receiver's done/rx_data outputs.
//  - Stores bytes in a DEPTH-entry FIFO.
//  - Presents them to the consumer over a first-word-fall-through valid/ready port.
//  - Flags dropped bytes with a sticky overflow bit.

---
 rtl/uart_pkg.sv | 4 +
 rtl/uart_sync_2ff.sv | 19 +
 rtl/uart_rx_fifo.sv | 57 +++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: constants shared by the UART receiver, transmitter and rx buffer
package uart_pkg;
  localparam int UART_DATA_W = 8;
endpackage

// File: rtl/uart_sync_2ff.sv
// uart_sync_2ff: two-flop level synchronizer with selectable reset value
module uart_sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic s1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= RST_VAL;
      q  <= RST_VAL;
    end else begin
      s1 <= d;
      q  <= s1;
    end
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive byte buffer with done-edge capture, fwft read port and sticky overflow
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH  = 16,
  parameter  int DATA_W = UART_DATA_W,
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_done,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  input  logic              ovf_clr
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic s2, s3, push, pop, wr, ovf;
  logic [CW-1:0] count_n;
  uart_sync_2ff #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst(rst), .d(rx_done), .q(s2));
  assign m_valid = ~empty;
  assign m_data = mem[rd_ptr];
  always_comb begin
    push = s2 & ~s3;
    pop = m_valid & m_ready;
    wr = push & (~full | pop);
    ovf = push & full & ~pop;
    count_n = (wr & ~pop) ? count + CW'(1) : (pop & ~wr) ? count - CW'(1) : count;
  end
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= rx_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s3 <= 1'b1;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      full <= 1'b0;
      empty <= 1'b1;
      overflow <= 1'b0;
    end else begin
      s3 <= s2;
      wr_ptr <= wr_ptr + AW'(wr);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count_n;
      full <= count_n == CW'(DEPTH);
      empty <= count_n == '0;
      overflow <= ovf | (overflow & ~ovf_clr);
    end
endmodule
